std_mem_d1_responder: RTL and testbench

// Memory-side responder for the one-dimensional memory port protocol that Calyx components drive.
// The protocol signals are addr0, write_data, write_en, read_data and done.
// It serves a component's external memory port (e.g. in_* / out_*) with a configurable write latency.
// - read_data: combinational.
// - done: registered one-cycle pulse per committed write.
// The initiator holds write_en until done and drops it in the done cycle.

---
 rtl/std_mem_d1_responder_if.sv | 29 ++
 rtl/std_mem_d1_responder.sv | 144 ++++++++++++++
 tb/tb_std_mem_d1_responder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/std_mem_d1_responder_if.sv
// One-dimensional memory port as driven by a Calyx component.
// The initiator owns address, write data and write enable. The responder
// returns combinational read data and a one-cycle done pulse per write.
interface std_mem_d1_responder_if #(
    parameter int WIDTH    = 32,
    parameter int IDX_SIZE = 4
);
    logic [IDX_SIZE-1:0] addr0;
    logic [WIDTH-1:0]    write_data;
    logic                write_en;
    logic [WIDTH-1:0]    read_data;
    logic                done;

    modport master (
        output addr0,
        output write_data,
        output write_en,
        input  read_data,
        input  done
    );

    modport slave (
        input  addr0,
        input  write_data,
        input  write_en,
        output read_data,
        output done
    );
endinterface

// File: rtl/std_mem_d1_responder.sv
// Memory-side responder for the Calyx std_mem_d1 port protocol.
// Reads are combinational from the array. A write is captured into hold
// registers on acceptance and committed WRITE_LATENCY cycles later, at
// which point done pulses for one cycle and write_count advances.
// Only the control state is reset; the array and hold registers are not.
module std_mem_d1_responder #(
    parameter int WIDTH         = 32,
    parameter int SIZE          = 16,
    parameter int IDX_SIZE      = 4,
    parameter int WRITE_LATENCY = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    std_mem_d1_responder_if.slave        port,
    output logic                         busy,
    output logic                         err_oob,
    output logic [15:0]                  write_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // SIZE widened by one bit so that SIZE == 2**IDX_SIZE compares correctly.
    localparam logic [IDX_SIZE:0] SIZE_EXT = (IDX_SIZE + 1)'(SIZE);
    // WAIT spends LAT_LOAD+1 edges counting down; the accept edge is the first.
    localparam logic [3:0] LAT_LOAD = 4'((WRITE_LATENCY > 1) ? (WRITE_LATENCY - 2) : 0);
    localparam bit SINGLE = (WRITE_LATENCY == 1);

    state_e              state_q;
    logic [3:0]          lat_cnt_q;
    logic                done_q;
    logic                busy_q;
    logic                err_oob_q;
    logic [15:0]         write_count_q;
    logic [15:0]         write_count_d;
    logic [IDX_SIZE-1:0] hold_addr_q;
    logic [WIDTH-1:0]    hold_data_q;
    logic [WIDTH-1:0]    mem_q [SIZE];

    logic                addr_oob;
    logic                accept;
    logic                commit;
    logic                commit_in_range;
    logic [IDX_SIZE-1:0] commit_addr;
    logic [WIDTH-1:0]    commit_data;

    // Request decode and commit selection. A single-cycle write commits the
    // live bus word at the accept edge; longer latencies commit the held word.
    // Commit is gated by reset so a write in flight is dropped, not stored.
    always_comb begin
        addr_oob        = ({1'b0, port.addr0} >= SIZE_EXT);
        accept          = (state_q == IDLE) && port.write_en;
        commit          = reset && ((accept && SINGLE) ||
                                    ((state_q == WAIT) && (lat_cnt_q == 4'd0)));
        commit_addr     = (state_q == IDLE) ? port.addr0 : hold_addr_q;
        commit_data     = (state_q == IDLE) ? port.write_data : hold_data_q;
        commit_in_range = ({1'b0, commit_addr} < SIZE_EXT);
        write_count_d   = write_count_q + 16'd1;
    end

    // Combinational read port; out-of-range addresses read as zero.
    always_comb begin
        port.read_data = '0;
        if (!addr_oob) begin
            port.read_data = mem_q[port.addr0];
        end
    end

    // Write FSM with registered done/busy/err_oob/write_count. The read port
    // is always live, so every cycle with an out-of-range address counts as
    // an observed out-of-bounds access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            lat_cnt_q     <= 4'd0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            err_oob_q     <= 1'b0;
            write_count_q <= 16'd0;
        end else begin
            done_q <= 1'b0;
            if (addr_oob) begin
                err_oob_q <= 1'b1;
            end
            if (commit) begin
                write_count_q <= write_count_d;
            end
            unique case (state_q)
                IDLE: begin
                    if (port.write_en) begin
                        if (SINGLE) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q   <= WAIT;
                            lat_cnt_q <= LAT_LOAD;
                            busy_q    <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (lat_cnt_q != 4'd0) begin
                        lat_cnt_q <= lat_cnt_q - 4'd1;
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                DONE: begin
                    // write_en is guaranteed low here by the initiator.
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Hold registers decouple the committed word from later bus changes.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_addr_q <= port.addr0;
            hold_data_q <= port.write_data;
        end
    end

    // Storage array; out-of-range commits complete without an update.
    always_ff @(posedge clk) begin
        if (commit && commit_in_range) begin
            mem_q[commit_addr] <= commit_data;
        end
    end

    assign port.done   = done_q;
    assign busy        = busy_q;
    assign err_oob     = err_oob_q;
    assign write_count = write_count_q;

endmodule

// File: tb/tb_std_mem_d1_responder.sv
// Bench for std_mem_d1_responder: four instances with different latency and
// size settings, checked against an array-based model of the memory rules.
module tb_std_mem_d1_responder;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [N-1:0][3:0]  addr_a;
    logic [N-1:0][31:0] wd_a;
    logic [N-1:0]       we_a;
    logic [N-1:0][31:0] rd_a;
    logic [N-1:0]       done_a;
    logic [N-1:0]       busy_a;
    logic [N-1:0]       err_a;
    logic [N-1:0][15:0] cnt_a;

    int wl_m [N] = '{1, 4, 2, 8};
    int sz_m [N] = '{16, 16, 10, 16};

    logic [31:0] mem_m   [N][16];
    bit          known_m [N][16];
    logic [15:0] cnt_m   [N];
    bit          err_m   [N];
    int          last_done [N];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int WL = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 2 : 8;
        localparam int SZ = (g == 2) ? 10 : 16;

        std_mem_d1_responder_if #(.WIDTH(32), .IDX_SIZE(4)) bus ();

        assign bus.addr0      = addr_a[g];
        assign bus.write_data = wd_a[g];
        assign bus.write_en   = we_a[g];
        assign rd_a[g]        = bus.read_data;
        assign done_a[g]      = bus.done;

        std_mem_d1_responder #(
            .WIDTH(32), .SIZE(SZ), .IDX_SIZE(4), .WRITE_LATENCY(WL)
        ) dut (
            .clk(clk),
            .reset(rst_n),
            .port(bus),
            .busy(busy_a[g]),
            .err_oob(err_a[g]),
            .write_count(cnt_a[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mref(input int i, input int a);
        return (a < sz_m[i]) ? mem_m[i][a] : 32'h0;
    endfunction

    // One clock: the model notes any out-of-range address present at the edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rst_n) begin
            for (int i = 0; i < N; i++) begin
                if (int'(addr_a[i]) >= sz_m[i]) err_m[i] = 1'b1;
            end
        end
        #1;
    endtask

    // Full write transaction on instance i, ending back in an idle cycle.
    task automatic do_write(input int i, input int a, input logic [31:0] d, input bit scramble);
        logic [31:0] old;
        bit          old_ok;
        int          n;
        bit          got;
        old    = mref(i, a);
        old_ok = (a >= sz_m[i]) || known_m[i][a];
        addr_a[i] = 4'(a);
        wd_a[i]   = d;
        we_a[i]   = 1'b1;
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            tick();
            n++;
            if (done_a[i]) begin
                got = 1'b1;
            end else begin
                check($sformatf("busy_wait[%0d]", i), 64'(busy_a[i]), 64'(wl_m[i] > 1));
                if (old_ok) check($sformatf("rd_old[%0d]", i), 64'(rd_a[i]), 64'(old));
                if (scramble) wd_a[i] = ~d;
            end
        end
        check($sformatf("latency[%0d]", i), 64'(n), 64'(wl_m[i]));
        check($sformatf("busy_done[%0d]", i), 64'(busy_a[i]), 64'(0));
        if (a < sz_m[i]) begin
            mem_m[i][a]   = d;
            known_m[i][a] = 1'b1;
        end
        cnt_m[i] = cnt_m[i] + 16'd1;
        last_done[i] = cyc;
        check($sformatf("count[%0d]", i), 64'(cnt_a[i]), 64'(cnt_m[i]));
        check($sformatf("rd_new[%0d]", i), 64'(rd_a[i]), 64'(mref(i, a)));
        check($sformatf("err[%0d]", i), 64'(err_a[i]), 64'(err_m[i]));
        we_a[i] = 1'b0;
        tick();
        check($sformatf("done_pulse[%0d]", i), 64'(done_a[i]), 64'(0));
    endtask

    task automatic sweep(input int i);
        for (int a = 0; a < 16; a++) begin
            addr_a[i] = 4'(a);
            #1;
            if (a >= sz_m[i] || known_m[i][a])
                check($sformatf("sweep[%0d][%0d]", i, a), 64'(rd_a[i]), 64'(mref(i, a)));
        end
        addr_a[i] = 4'd0;
    endtask

    initial begin
        int          t0;
        logic [31:0] old7;
        addr_a = '0;
        wd_a   = '0;
        we_a   = '0;
        for (int i = 0; i < N; i++) begin
            cnt_m[i] = 16'd0;
            err_m[i] = 1'b0;
            last_done[i] = 0;
            for (int a = 0; a < 16; a++) begin
                mem_m[i][a]   = 32'h0;
                known_m[i][a] = 1'b0;
            end
        end

        // Reset state
        tick();
        tick();
        for (int i = 0; i < N; i++) begin
            check($sformatf("rst_done[%0d]", i), 64'(done_a[i]), 64'(0));
            check($sformatf("rst_busy[%0d]", i), 64'(busy_a[i]), 64'(0));
            check($sformatf("rst_err[%0d]", i), 64'(err_a[i]), 64'(0));
            check($sformatf("rst_cnt[%0d]", i), 64'(cnt_a[i]), 64'(0));
        end
        rst_n = 1'b1;
        tick();

        // Fill every in-range word so reads are fully predictable
        for (int i = 0; i < N; i++) begin
            for (int a = 0; a < sz_m[i]; a++) do_write(i, a, $urandom, 1'b0);
        end

        // Single-cycle write
        do_write(0, 3, 32'hDEAD_BEEF, 1'b0);

        // Latency 4 with write_data disturbed during WAIT
        do_write(1, 5, 32'd7, 1'b1);
        check("t2_rd5", 64'(rd_a[1]), 64'(32'd7));

        // Back-to-back writes at latency 2
        do_write(2, 0, 32'd1, 1'b0);
        t0 = last_done[2];
        do_write(2, 1, 32'd2, 1'b0);
        check("t3_spacing", 64'(last_done[2] - t0), 64'(3));

        // Out-of-bounds write on the 10-word instance
        check("t4_err_before", 64'(err_a[2]), 64'(0));
        do_write(2, 12, 32'hA5A5_A5A5, 1'b0);
        check("t4_rd12", 64'(rd_a[2]), 64'(0));
        sweep(2);
        tick();
        check("t4_err_sticky", 64'(err_a[2]), 64'(1));

        // Output word written by a top-level component
        do_write(0, 0, 32'd42, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 60; k++) begin
            do_write(int'($urandom_range(0, N - 1)), int'($urandom_range(0, 15)),
                     $urandom, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < N; i++) sweep(i);

        // Reset during WAIT at latency 8
        addr_a = '0;
        tick();
        old7 = mref(3, 7);
        addr_a[3] = 4'd7;
        wd_a[3]   = ~old7;
        we_a[3]   = 1'b1;
        tick();
        tick();
        tick();
        check("t5_busy_pre", 64'(busy_a[3]), 64'(1));
        rst_n = 1'b0;
        #1;
        check("t5_busy_rst", 64'(busy_a[3]), 64'(0));
        check("t5_done_rst", 64'(done_a[3]), 64'(0));
        check("t5_cnt_rst", 64'(cnt_a[3]), 64'(0));
        we_a[3] = 1'b0;
        for (int i = 0; i < N; i++) begin
            cnt_m[i] = 16'd0;
            err_m[i] = 1'b0;
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t5_no_done", 64'(done_a[3]), 64'(0));
        end
        check("t5_rd7", 64'(rd_a[3]), 64'(old7));
        for (int i = 0; i < N; i++) begin
            check($sformatf("t5_cnt[%0d]", i), 64'(cnt_a[i]), 64'(cnt_m[i]));
            check($sformatf("t5_err[%0d]", i), 64'(err_a[i]), 64'(err_m[i]));
        end
        do_write(3, 7, 32'h1234_5678, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
